// File: rtl/store_lane_buffer_if.sv
// ----------------------------------------------------------------------------
// store_lane_buffer_if
//  Groups the store-request and data-memory handshake signals of
//  store_lane_buffer into one bundle.
//  Ports (signals):
//   iValid/oReady/iAddr/iData/iSize  store request from the MEM stage
//   oMisalign                        one-cycle pulse: last offered store rejected
//   oMemValid/iMemReady              head entry handshake toward data memory
//   oMemAddr/oMemData/oMemBe         word address, lane data, byte enables
//   oCount                           entries currently held
//  Modports: slave = the buffer itself, master = the environment driving it.
// ----------------------------------------------------------------------------
interface store_lane_buffer_if #(
  parameter int CW = 3
);
  logic          iValid;
  logic          oReady;
  logic [31:0]   iAddr;
  logic [31:0]   iData;
  logic [1:0]    iSize;
  logic          oMisalign;
  logic          oMemValid;
  logic          iMemReady;
  logic [31:0]   oMemAddr;
  logic [31:0]   oMemData;
  logic [3:0]    oMemBe;
  logic [CW-1:0] oCount;

  modport slave (
    input  iValid, iAddr, iData, iSize, iMemReady,
    output oReady, oMisalign, oMemValid, oMemAddr, oMemData, oMemBe, oCount
  );

  modport master (
    output iValid, iAddr, iData, iSize, iMemReady,
    input  oReady, oMisalign, oMemValid, oMemAddr, oMemData, oMemBe, oCount
  );
endinterface

// File: rtl/store_lane_buffer.sv
// ----------------------------------------------------------------------------
// store_lane_buffer
//  Narrows a 32-bit register value to byte/halfword/word, places it on the
//  correct little-endian byte lane with byte enables, and queues aligned
//  stores in a DEPTH-entry FIFO that drains to data memory over valid/ready.
//  Ports:
//   iClk   clock, all state on the rising edge
//   iRst_n asynchronous active-low reset; discards all pending entries
//   bus    store_lane_buffer_if.slave (request side + memory side + oCount)
//  oReady and oMemValid are registered copies of (count != DEPTH) and
//  (count != 0); neither depends combinationally on any input, so there is
//  no ready path from iMemReady and no same-cycle bypass to memory.
// ----------------------------------------------------------------------------
module store_lane_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  store_lane_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  // FIFO storage
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_be   [DEPTH];

  // Control state
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_mem_valid;
  logic          r_misalign;

  // Combinational helpers
  logic [1:0]    w_lo;
  logic [31:0]   w_pack_data;
  logic [3:0]    w_pack_be;
  logic          w_aligned;
  logic          w_push;
  logic          w_pop;
  logic          w_reject;
  logic [CW-1:0] w_count_nxt;

  // Lane packing and alignment check of the offered store
  always_comb begin
    w_lo        = bus.iAddr[1:0];
    w_pack_data = 32'h0000_0000;
    w_pack_be   = 4'b0000;
    w_aligned   = 1'b0;
    case (bus.iSize)
      2'b00: begin
        w_pack_data = {4{bus.iData[7:0]}};
        w_pack_be   = 4'b0001 << w_lo;
        w_aligned   = 1'b1;
      end
      2'b01: begin
        w_pack_data = {2{bus.iData[15:0]}};
        w_pack_be   = bus.iAddr[1] ? 4'b1100 : 4'b0011;
        w_aligned   = ~bus.iAddr[0];
      end
      2'b10: begin
        w_pack_data = bus.iData;
        w_pack_be   = 4'b1111;
        w_aligned   = (w_lo == 2'b00);
      end
      default: begin
        // reserved size: rejected like a misaligned store
        w_pack_data = 32'h0000_0000;
        w_pack_be   = 4'b0000;
        w_aligned   = 1'b0;
      end
    endcase
  end

  // Handshake decode and next occupancy
  always_comb begin
    w_push   = bus.iValid & r_ready & w_aligned;
    w_reject = bus.iValid & r_ready & ~w_aligned;
    w_pop    = r_mem_valid & bus.iMemReady;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage: write packed store at the tail slot on accept
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 32'h0000_0000;
        r_data[i] <= 32'h0000_0000;
        r_be[i]   <= 4'b0000;
      end
    end else if (w_push) begin
      r_addr[r_tail] <= {bus.iAddr[31:2], 2'b00};
      r_data[r_tail] <= w_pack_data;
      r_be[r_tail]   <= w_pack_be;
    end
  end

  // Pointers, occupancy, registered ready/valid and misalign pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= CNT_ZERO;
      r_ready     <= 1'b1;
      r_mem_valid <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      // power-of-two depth: pointers wrap naturally
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      r_count     <= w_count_nxt;
      r_ready     <= (w_count_nxt != CNT_FULL);
      r_mem_valid <= (w_count_nxt != CNT_ZERO);
      r_misalign  <= w_reject;
    end
  end

  // Head fields are read straight from storage; stale when empty, qualified by oMemValid
  assign bus.oReady    = r_ready;
  assign bus.oMemValid = r_mem_valid;
  assign bus.oMisalign = r_misalign;
  assign bus.oCount    = r_count;
  assign bus.oMemAddr  = r_addr[r_head];
  assign bus.oMemData  = r_data[r_head];
  assign bus.oMemBe    = r_be[r_head];

endmodule
